// File: rtl/potential_accumulate_decay_pkg.sv
// potential_accumulate_decay_pkg: shared state encoding, constants and float compare helper
package potential_accumulate_decay_pkg;
  typedef enum logic [1:0] {INIT, ACCUM, DECAY, ISSUE} state_e;
  localparam logic [31:0] FP_ZERO = 32'h00000000;
  localparam int SPIKE_CNT_W = 16;
  function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
    return (a[31] != b[31]) ? (!a[31] || (a[30:0] == 31'd0 && b[30:0] == 31'd0))
         : a[31] ? (a[30:0] <= b[30:0]) : (a[30:0] >= b[30:0]);
  endfunction
endpackage

// File: rtl/Addition_Subtraction.sv
// Addition_Subtraction: IEEE-754 single add/sub, truncating, subnormals treated as zero-exponent values
module Addition_Subtraction (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic        Exception,
  output logic [31:0] result
);
  logic [31:0] b_eff, op_big, op_sml;
  logic [7:0] e_diff;
  logic [23:0] m_big, m_sml;
  logic [24:0] m_sum;
  logic [4:0] lz;
  // align the smaller magnitude, add or subtract, then renormalise
  always_comb begin
    b_eff = {b_operand[31] ^ AddBar_Sub, b_operand[30:0]};
    op_big = (a_operand[30:0] < b_eff[30:0]) ? b_eff : a_operand;
    op_sml = (a_operand[30:0] < b_eff[30:0]) ? a_operand : b_eff;
    Exception = (&a_operand[30:23]) | (&b_operand[30:23]);
    e_diff = op_big[30:23] - op_sml[30:23];
    m_big = {|op_big[30:23], op_big[22:0]};
    m_sml = (e_diff > 8'd24) ? 24'd0 : {|op_sml[30:23], op_sml[22:0]} >> e_diff;
    m_sum = (op_big[31] ^ op_sml[31]) ? {1'b0, m_big} - {1'b0, m_sml} : {1'b0, m_big} + {1'b0, m_sml};
    lz = 5'd0;
    for (int i = 0; i < 24; i++) lz = m_sum[i] ? 5'(23 - i) : lz;
    result = m_sum[24] ? {op_big[31], op_big[30:23] + 8'd1, m_sum[23:1]}
           : (m_sum == 25'd0 || op_big[30:23] <= {3'b0, lz}) ? 32'd0
           : {op_big[31], op_big[30:23] - {3'b0, lz}, 23'(m_sum[23:0] << lz)};
  end
endmodule

// File: rtl/Multiplication.sv
// Multiplication: IEEE-754 single multiply, truncating, zero-exponent operands give zero
module Multiplication (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow,
  output logic [31:0] result
);
  logic [24:0] prod;
  logic [9:0] e_sum;
  logic zero;
  // mantissa product, exponent sum with range flags
  always_comb begin
    zero = ~|a_operand[30:23] | ~|b_operand[30:23];
    prod = 25'((48'({1'b1, a_operand[22:0]}) * 48'({1'b1, b_operand[22:0]})) >> 23);
    e_sum = {2'b0, a_operand[30:23]} + {2'b0, b_operand[30:23]} - 10'd127 + {9'd0, prod[24]};
    Exception = (&a_operand[30:23]) | (&b_operand[30:23]);
    Overflow = !zero && !Exception && !e_sum[9] && e_sum >= 10'd255;
    Underflow = !zero && !Exception && (e_sum[9] || e_sum == 10'd0);
    result = zero ? 32'd0 : {a_operand[31] ^ b_operand[31], e_sum[7:0], prod[24] ? prod[23:1] : prod[22:0]};
  end
endmodule

// File: rtl/potential_adder_0.sv
// potential_adder_0: combinational LIF adder with loadable threshold and subtractive reset
module potential_adder_0
  import potential_accumulate_decay_pkg::*;
#(
  parameter logic [31:0] THRESHOLD = 32'h42200000
) (
  input  logic        clk,
  input  logic        set,
  input  logic        clear,
  input  logic [31:0] input_weight,
  input  logic [31:0] decayed_potential,
  output logic [31:0] final_potential,
  output logic        spike
);
  logic [31:0] thr_q, thr_d, sum, diff;
  logic sum_exc, diff_exc;
  Addition_Subtraction u_sum (.a_operand(decayed_potential), .b_operand(input_weight), .AddBar_Sub(1'b0), .Exception(sum_exc), .result(sum));
  Addition_Subtraction u_diff (.a_operand(sum), .b_operand(thr_q), .AddBar_Sub(1'b1), .Exception(diff_exc), .result(diff));
  // threshold load, spike decision and reset-by-subtraction
  always_comb begin
    thr_d = set ? THRESHOLD : thr_q;
    spike = !clear && !sum_exc && fp_ge(sum, thr_q);
    final_potential = (clear || sum_exc || diff_exc) ? FP_ZERO : spike ? diff : sum;
  end
  // threshold register
  always_ff @(posedge clk) thr_q <= thr_d;
endmodule

// File: rtl/potential_accumulate_decay.sv
// potential_accumulate_decay: accumulates weighted events and drives the LIF adder each timestep
module potential_accumulate_decay
  import potential_accumulate_decay_pkg::*;
#(
  parameter int SPIKE_CNT_W = potential_accumulate_decay_pkg::SPIKE_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   timestep,
  input  logic [31:0]            decay_factor,
  input  logic                   ev_valid,
  input  logic [31:0]            ev_weight,
  output logic                   ev_ready,
  output logic [31:0]            input_weight,
  output logic [31:0]            decayed_potential,
  output logic                   adder_clear,
  output logic                   adder_set,
  input  logic [31:0]            final_potential_in,
  input  logic                   spike_in,
  output logic                   spike_out,
  output logic [SPIKE_CNT_W-1:0] spike_count,
  output logic                   ts_overrun,
  output logic                   arith_err
);
  state_e state_q, state_d;
  logic [31:0] acc_q, acc_d, v_mem_q, v_mem_d, input_weight_q, input_weight_d, decayed_q, decayed_d;
  logic [31:0] add_res, mul_res;
  logic [SPIKE_CNT_W-1:0] cnt_q, cnt_d;
  logic spike_q, spike_d, ovr_q, ovr_d, err_q, err_d;
  logic add_exc, mul_exc, mul_ovf, mul_unf;
  Addition_Subtraction u_acc_add (.a_operand(acc_q), .b_operand(ev_weight), .AddBar_Sub(1'b0), .Exception(add_exc), .result(add_res));
  Multiplication u_decay_mul (.a_operand(v_mem_q), .b_operand(decay_factor), .Exception(mul_exc), .Overflow(mul_ovf), .Underflow(mul_unf), .result(mul_res));
  assign input_weight = input_weight_q;
  assign decayed_potential = decayed_q;
  assign spike_out = spike_q;
  assign spike_count = cnt_q;
  assign ts_overrun = ovr_q;
  assign arith_err = err_q;
  // next state, datapath updates and handshake outputs
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    v_mem_d = v_mem_q;
    input_weight_d = input_weight_q;
    decayed_d = decayed_q;
    spike_d = 1'b0;
    cnt_d = cnt_q;
    ovr_d = ovr_q | (timestep & (state_q == DECAY || state_q == ISSUE));
    err_d = err_q;
    ev_ready = state_q == ACCUM;
    adder_clear = state_q != ISSUE;
    adder_set = rst_n & (state_q == INIT);
    case (state_q)
      INIT: state_d = ACCUM;
      ACCUM: begin
        acc_d = (ev_valid & ~add_exc) ? add_res : acc_q;
        err_d = err_q | (ev_valid & add_exc);
        state_d = timestep ? DECAY : ACCUM;
      end
      DECAY: begin
        decayed_d = (mul_exc | mul_ovf | mul_unf) ? FP_ZERO : mul_res;
        err_d = err_q | mul_exc | mul_ovf;
        input_weight_d = acc_q;
        state_d = ISSUE;
      end
      default: begin
        v_mem_d = final_potential_in;
        spike_d = spike_in;
        cnt_d = (spike_in & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
        acc_d = FP_ZERO;
        state_d = ACCUM;
      end
    endcase
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      acc_q <= FP_ZERO;
      v_mem_q <= FP_ZERO;
      input_weight_q <= FP_ZERO;
      decayed_q <= FP_ZERO;
      spike_q <= 1'b0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      v_mem_q <= v_mem_d;
      input_weight_q <= input_weight_d;
      decayed_q <= decayed_d;
      spike_q <= spike_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_potential_accumulate_decay.sv
// tb_potential_accumulate_decay: directed checks of the accumulate/decay front-end with its LIF adder
module tb_potential_accumulate_decay;
  localparam int CW = 4;
  logic clk = 1'b0, rst_n, timestep, ev_valid, ev_ready, adder_clear, adder_set, spike, spike_out, ts_overrun, arith_err;
  logic [31:0] decay_factor, ev_weight, input_weight, decayed_potential, final_potential;
  logic [CW-1:0] spike_count;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  potential_accumulate_decay #(.SPIKE_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .timestep(timestep), .decay_factor(decay_factor),
    .ev_valid(ev_valid), .ev_weight(ev_weight), .ev_ready(ev_ready),
    .input_weight(input_weight), .decayed_potential(decayed_potential),
    .adder_clear(adder_clear), .adder_set(adder_set),
    .final_potential_in(final_potential), .spike_in(spike),
    .spike_out(spike_out), .spike_count(spike_count), .ts_overrun(ts_overrun), .arith_err(arith_err)
  );
  potential_adder_0 u_adder (
    .clk(clk), .set(adder_set), .clear(adder_clear), .input_weight(input_weight),
    .decayed_potential(decayed_potential), .final_potential(final_potential), .spike(spike)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start;
    rst_n = 1'b0; ev_valid = 1'b0; timestep = 1'b0; ev_weight = 32'h0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask
  task automatic send(input logic [31:0] w);
    ev_valid = 1'b1; ev_weight = w;
    tick;
    ev_valid = 1'b0;
  endtask
  task automatic pulse_ts;
    timestep = 1'b1;
    tick;
    timestep = 1'b0;
  endtask
  task automatic test_reset;
    decay_factor = 32'h3F000000;
    rst_n = 1'b0; ev_valid = 1'b0; timestep = 1'b0; ev_weight = 32'h0;
    tick;
    tick;
    n_cmp++; if ({adder_set, ev_ready, adder_clear, spike_out, ts_overrun, arith_err} !== 6'b001000) begin n_err++; $display("FAIL rst_ctrl got %b exp %b", {adder_set, ev_ready, adder_clear, spike_out, ts_overrun, arith_err}, 6'b001000); end
    n_cmp++; if ({input_weight, decayed_potential} !== 64'h0) begin n_err++; $display("FAIL rst_data got %h exp %h", {input_weight, decayed_potential}, 64'h0); end
    n_cmp++; if (spike_count !== 4'h0) begin n_err++; $display("FAIL rst_cnt got %h exp %h", spike_count, 4'h0); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if ({adder_set, ev_ready} !== 2'b10) begin n_err++; $display("FAIL init_set got %b exp %b", {adder_set, ev_ready}, 2'b10); end
    tick;
    n_cmp++; if ({adder_set, ev_ready, adder_clear} !== 3'b011) begin n_err++; $display("FAIL accum_entry got %b exp %b", {adder_set, ev_ready, adder_clear}, 3'b011); end
  endtask
  task automatic test_accumulate;
    decay_factor = 32'h3F000000;
    start;
    send(32'h3F800000);
    send(32'h40000000);
    pulse_ts;
    n_cmp++; if ({ev_ready, adder_clear} !== 2'b01) begin n_err++; $display("FAIL decay_ctrl got %b exp %b", {ev_ready, adder_clear}, 2'b01); end
    tick;
    n_cmp++; if (input_weight !== 32'h40400000) begin n_err++; $display("FAIL acc_iw got %h exp %h", input_weight, 32'h40400000); end
    n_cmp++; if (decayed_potential !== 32'h0) begin n_err++; $display("FAIL acc_dp got %h exp %h", decayed_potential, 32'h0); end
    n_cmp++; if ({ev_ready, adder_clear} !== 2'b00) begin n_err++; $display("FAIL issue_ctrl got %b exp %b", {ev_ready, adder_clear}, 2'b00); end
    n_cmp++; if (final_potential !== 32'h40400000) begin n_err++; $display("FAIL acc_vmem got %h exp %h", final_potential, 32'h40400000); end
    tick;
    n_cmp++; if ({spike_out, ev_ready, adder_clear} !== 3'b011) begin n_err++; $display("FAIL acc_t3 got %b exp %b", {spike_out, ev_ready, adder_clear}, 3'b011); end
    pulse_ts;
    tick;
    n_cmp++; if ({input_weight, decayed_potential} !== {32'h0, 32'h3FC00000}) begin n_err++; $display("FAIL acc_decay got %h exp %h", {input_weight, decayed_potential}, {32'h0, 32'h3FC00000}); end
    tick;
  endtask
  task automatic test_spike;
    decay_factor = 32'h3F000000;
    start;
    send(32'h42340000);
    pulse_ts;
    tick;
    n_cmp++; if ({spike, final_potential} !== {1'b1, 32'h40A00000}) begin n_err++; $display("FAIL spk_adder got %h exp %h", {spike, final_potential}, {1'b1, 32'h40A00000}); end
    tick;
    n_cmp++; if ({spike_out, spike_count} !== {1'b1, 4'h1}) begin n_err++; $display("FAIL spk_out got %h exp %h", {spike_out, spike_count}, {1'b1, 4'h1}); end
    tick;
    n_cmp++; if (spike_out !== 1'b0) begin n_err++; $display("FAIL spk_pulse got %b exp %b", spike_out, 1'b0); end
    pulse_ts;
    tick;
    n_cmp++; if (decayed_potential !== 32'h40200000) begin n_err++; $display("FAIL spk_decay got %h exp %h", decayed_potential, 32'h40200000); end
    tick;
    n_cmp++; if ({spike_out, spike_count} !== {1'b0, 4'h1}) begin n_err++; $display("FAIL spk_count got %h exp %h", {spike_out, spike_count}, {1'b0, 4'h1}); end
  endtask
  task automatic test_simultaneous;
    decay_factor = 32'h3F000000;
    start;
    send(32'h40000000);
    ev_valid = 1'b1; ev_weight = 32'h3F800000; timestep = 1'b1;
    tick;
    timestep = 1'b0; ev_weight = 32'h41200000;
    n_cmp++; if (ev_ready !== 1'b0) begin n_err++; $display("FAIL sim_t1_ready got %b exp %b", ev_ready, 1'b0); end
    tick;
    n_cmp++; if ({ev_ready, input_weight} !== {1'b0, 32'h40400000}) begin n_err++; $display("FAIL sim_iw got %h exp %h", {ev_ready, input_weight}, {1'b0, 32'h40400000}); end
    tick;
    n_cmp++; if (ev_ready !== 1'b1) begin n_err++; $display("FAIL sim_t3_ready got %b exp %b", ev_ready, 1'b1); end
    tick;
    ev_valid = 1'b0;
    pulse_ts;
    tick;
    n_cmp++; if (input_weight !== 32'h41200000) begin n_err++; $display("FAIL sim_held got %h exp %h", input_weight, 32'h41200000); end
    tick;
  endtask
  task automatic test_drop;
    decay_factor = 32'h3F000000;
    start;
    send(32'h3F800000);
    timestep = 1'b1;
    tick;
    tick;
    timestep = 1'b0;
    n_cmp++; if ({ts_overrun, adder_clear} !== 2'b10) begin n_err++; $display("FAIL drop_flag got %b exp %b", {ts_overrun, adder_clear}, 2'b10); end
    tick;
    n_cmp++; if ({ev_ready, adder_clear} !== 2'b11) begin n_err++; $display("FAIL drop_t3 got %b exp %b", {ev_ready, adder_clear}, 2'b11); end
    tick;
    n_cmp++; if ({ev_ready, adder_clear, ts_overrun} !== 3'b111) begin n_err++; $display("FAIL drop_single got %b exp %b", {ev_ready, adder_clear, ts_overrun}, 3'b111); end
    decay_factor = 32'h40000000;
    start;
    n_cmp++; if ({ts_overrun, arith_err} !== 2'b00) begin n_err++; $display("FAIL flags_clear got %b exp %b", {ts_overrun, arith_err}, 2'b00); end
    send(32'h7F000000);
    pulse_ts;
    tick;
    n_cmp++; if (final_potential !== 32'h7F000000) begin n_err++; $display("FAIL ovf_vmem got %h exp %h", final_potential, 32'h7F000000); end
    tick;
    n_cmp++; if (arith_err !== 1'b0) begin n_err++; $display("FAIL ovf_pre got %b exp %b", arith_err, 1'b0); end
    pulse_ts;
    tick;
    n_cmp++; if ({decayed_potential, arith_err} !== {32'h0, 1'b1}) begin n_err++; $display("FAIL ovf_mul got %h exp %h", {decayed_potential, arith_err}, {32'h0, 1'b1}); end
    tick;
  endtask
  task automatic test_reset_mid;
    decay_factor = 32'h3F000000;
    start;
    send(32'h42340000);
    pulse_ts;
    tick;
    tick;
    send(32'h3F800000);
    pulse_ts;
    rst_n = 1'b0;
    tick;
    n_cmp++; if ({input_weight, decayed_potential, spike_count} !== {32'h0, 32'h0, 4'h0}) begin n_err++; $display("FAIL mid_regs got %h exp %h", {input_weight, decayed_potential, spike_count}, {32'h0, 32'h0, 4'h0}); end
    n_cmp++; if ({adder_set, ev_ready, adder_clear, spike_out} !== 4'b0010) begin n_err++; $display("FAIL mid_ctrl got %b exp %b", {adder_set, ev_ready, adder_clear, spike_out}, 4'b0010); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (adder_set !== 1'b1) begin n_err++; $display("FAIL mid_init got %b exp %b", adder_set, 1'b1); end
    tick;
    pulse_ts;
    tick;
    n_cmp++; if ({input_weight, decayed_potential} !== 64'h0) begin n_err++; $display("FAIL mid_discard got %h exp %h", {input_weight, decayed_potential}, 64'h0); end
    tick;
  endtask
  task automatic test_saturate;
    decay_factor = 32'h3F000000;
    start;
    for (int i = 0; i < 15; i++) begin
      send(32'h42340000);
      pulse_ts;
      tick;
      tick;
    end
    n_cmp++; if (spike_count !== 4'hF) begin n_err++; $display("FAIL sat_full got %h exp %h", spike_count, 4'hF); end
    send(32'h42340000);
    pulse_ts;
    tick;
    n_cmp++; if (spike !== 1'b1) begin n_err++; $display("FAIL sat_spike got %b exp %b", spike, 1'b1); end
    tick;
    n_cmp++; if ({spike_out, spike_count} !== {1'b1, 4'hF}) begin n_err++; $display("FAIL sat_hold got %h exp %h", {spike_out, spike_count}, {1'b1, 4'hF}); end
  endtask
  initial begin
    test_reset;
    test_accumulate;
    test_spike;
    test_simultaneous;
    test_drop;
    test_reset_mid;
    test_saturate;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/potential_accumulate_decay.md
# potential_accumulate_decay

Per-neuron front-end stage that sits directly upstream of the combinational LIF potential adder. It collects weighted input spike events during a timestep and sums them in IEEE-754 single precision. At each timestep boundary it decays the stored membrane potential and presents `input_weight` and `decayed_potential` to the adder for one cycle. It then captures the adder's `final_potential` and `spike` back into its own state register.

## Interface
- `SPIKE_CNT_W`, default 16: width of the saturating spike counter.
- `clk`  in  1: single clock; every register updates on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `timestep`  in  1: one-cycle pulse that marks the end of the current timestep.
- `decay_factor`  in  32: IEEE-754 multiplier applied to `v_mem`; must be held stable.
- `ev_valid`  in  1: an incoming weighted spike event is present.
- `ev_weight`  in  32: IEEE-754 weight of the event.
- `ev_ready`  out  1: event accepted when `ev_valid & ev_ready`.
- `input_weight`  out  32: accumulated weight sum, to the adder.
- `decayed_potential`  out  32: `v_mem × decay_factor`, registered, to the adder.
- `adder_clear`  out  1: drives the adder `clear`; low only during ISSUE.
- `adder_set`  out  1: drives the adder `set`; high for exactly one cycle after reset is released.
- `final_potential_in`  in  32: adder result.
- `spike_in`  in  1: adder spike.
- `spike_out`  out  1: registered one-cycle spike pulse.
- `spike_count`  out  SPIKE_CNT_W: saturating total of spikes.
- `ts_overrun`  out  1: sticky flag; set when a `timestep` pulse is dropped.
- `arith_err`  out  1: sticky flag; set on any adder or multiplier exception.

## Operation
- **Reset values.** `rst_n=0` sets the state to INIT. `acc`, `v_mem`, `input_weight`, `decayed_potential`, `spike_count`, `ts_overrun` and `arith_err` all become 0. `spike_out=0`, `ev_ready=0`, `adder_clear=1`, `adder_set=0`.
- **INIT** lasts one cycle.
  - `adder_set=1` so the adder loads its threshold and model.
  - Next state is ACCUM.
- **ACCUM**
  - `ev_ready=1`.
  - Each accepted event performs `acc <= acc + ev_weight` through one `Addition_Subtraction` instance, with the sub flag at 0. Throughput is one event per cycle.
  - If the adder raises Exception, `acc` is held and `arith_err` is set.
  - On `timestep=1` the next state is DECAY.
  - If an event is accepted in the same cycle as `timestep`, that event belongs to the closing timestep.
- **DECAY**
  - `ev_ready=0`.
  - `decayed_potential <= v_mem × decay_factor` via one `Multiplication` instance.
  - Multiplier outputs:
    - Underflow: the result is forced to 0.
    - Exception or Overflow: the result is forced to 0 and `arith_err` is set.
  - `input_weight <= acc`.
  - Next state is ISSUE.
- **ISSUE**
  - `ev_ready=0`, `adder_clear=0`.
  - At the end of the cycle: `v_mem <= final_potential_in` and `spike_out <= spike_in`.
  - `spike_count` increments on a spike and saturates at all-ones.
  - `acc <= 0`.
  - Next state is ACCUM.
- **Dropped timestep.** A `timestep` pulse that arrives while in DECAY or ISSUE is ignored and sets `ts_overrun`. The sticky flags clear only on reset.
- **Output hold.** `input_weight` and `decayed_potential` keep their values until the next DECAY.
- **Reset mid-operation.** Any state goes to INIT on the next edge. A partially accumulated sum is discarded.

## Timing
- `timestep` high in cycle T, state ACCUM:
  - DECAY in T+1.
  - ISSUE in T+2, with `adder_clear=0` and both adder operands valid.
  - `spike_out` and the new `v_mem` visible in T+3.
  - `ev_ready=1` again in T+3.
- Total latency from `timestep` to `spike_out` is 3 cycles.
- Events are stalled (`ev_ready=0`) for exactly 2 cycles per timestep.
- The minimum legal `timestep` spacing is 3 cycles. Closer pulses set `ts_overrun`.
- The path through the combinational adder, from registered outputs to `final_potential_in`, must close within one cycle.

## Structure
- Shared package holds:
  - state encoding constants: INIT, ACCUM, DECAY, ISSUE;
  - `FP_ZERO = 32'h00000000`;
  - `SPIKE_CNT_W`.
- Reuse the existing `Addition_Subtraction` module (one instance) and `Multiplication` module (one instance).
- No new sub-modules.
- The bench instantiates this block together with `potential_adder_0` (threshold 40.0 = 0x42200000).

## Test plan
- **Reset release.** Release `rst_n` → `adder_set=1` for exactly one cycle, then `ev_ready=1`. All outputs are 0 and `adder_clear=1`.
- **Accumulation.** Events 0x3F800000 (1.0) and 0x40000000 (2.0), then `timestep`, with `decay_factor` 0x3F000000 (0.5) → at T+2 `input_weight=0x40400000` and `decayed_potential=0`. At T+3 `spike_out=0` and `v_mem=0x40400000`.
- **Spike.** Event 0x42340000 (45.0), then `timestep` → `spike_out=1` at T+3 and `v_mem=0x40A00000` (5.0). Next `timestep` with no events → `decayed_potential=0x40200000` (2.5) and `spike_count=1`.
- **Simultaneous event and timestep.** `ev_valid` with 1.0 in the same cycle as `timestep` → `input_weight` includes 1.0. `ev_valid` held during DECAY or ISSUE is not accepted until T+3.
- **Dropped timestep.** A second `timestep` at T+1 → `ts_overrun=1` and only one ISSUE occurs. A multiplier overflow from `v_mem=0x7F000000` with `decay_factor=0x40000000` → `decayed_potential=0` and `arith_err=1`.
- **Reset mid-DECAY.** Assert `rst_n=0` during DECAY → state INIT and all registers 0. Saturation: preload 0xFFFF spikes, then one more spike → `spike_count` stays 0xFFFF.
